uart_core: RTL and testbench

Full-duplex 8N1 UART transceiver with a runtime-programmable baud prescaler and 24x oversampling. It serializes bytes presented on a valid/busy handshake and deserializes incoming frames into single-cycle valid pulses. It serves both as the SoC's console/upgrade UART and as the host-side model in system benches.

---
 rtl/uart_core.sv | 146 ++++++++++++++
 tb/tb_uart_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART with a runtime baud prescaler and 24x oversampling.
// TX and RX share one baud tick but are otherwise independent.
module uart_core #(
    parameter int OVERSAMPLE = 24
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [7:0] baudrate_cfg,
    input  logic       rx,
    output logic       tx,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       rx_valid,
    output logic [7:0] rx_data
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

    logic [7:0] cnt_q, cnt_d;
    logic tick;
    tx_state_e tx_state_q, tx_state_d;
    logic [TW-1:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic tx_q, tx_d, tx_busy_q, tx_busy_d;
    logic rx_s1_q, rx_s2_q;
    rx_state_e rx_state_q, rx_state_d;
    logic [TW-1:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic rx_valid_q, rx_valid_d;

    // A lowered cfg leaves the count above it; wrap silently without a tick.
    assign tick = (cnt_q == baudrate_cfg);
    assign cnt_d = (cnt_q >= baudrate_cfg) ? 8'd0 : cnt_q + 8'd1;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d = tx_tcnt_q;
        tx_bit_d = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d = tx_q;
        tx_busy_d = tx_busy_q;
        if (tx_state_q == TX_IDLE) begin
            if (tx_valid && !tx_busy_q) begin
                tx_state_d = TX_START;
                tx_shift_d = tx_data;
                tx_busy_d = 1'b1;
                tx_tcnt_d = '0;
                tx_bit_d = '0;
            end
        end else if (tick) begin
            tx_tcnt_d = (tx_tcnt_q == LAST) ? '0 : tx_tcnt_q + 1'b1;
            // Each bit is launched on its first tick and held for the full bit time.
            if (tx_tcnt_q == '0)
                tx_d = (tx_state_q == TX_START) ? 1'b0 : (tx_state_q == TX_DATA) ? tx_shift_q[tx_bit_q] : 1'b1;
            if (tx_tcnt_q == LAST) begin
                tx_state_d = (tx_state_q == TX_STOP) ? TX_IDLE : (tx_state_q == TX_DATA && tx_bit_q == 3'd7) ? TX_STOP : TX_DATA;
                tx_bit_d = (tx_state_q == TX_DATA) ? tx_bit_q + 3'd1 : tx_bit_q;
                tx_busy_d = (tx_state_q != TX_STOP);
            end
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d = rx_tcnt_q;
        rx_bit_d = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d = rx_data_q;
        rx_valid_d = 1'b0;
        if (rx_state_q == RX_IDLE) begin
            if (tick && !rx_s2_q) begin
                rx_state_d = RX_START;
                rx_tcnt_d = '0;
                rx_bit_d = '0;
            end
        end else if (rx_state_q == RX_WAIT) begin
            if (rx_s2_q)
                rx_state_d = RX_IDLE;
        end else if (tick) begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
            if (rx_state_q == RX_START && rx_tcnt_q == MID) begin
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                rx_tcnt_d = '0;
            end else if (rx_state_q != RX_START && rx_tcnt_q == LAST) begin
                rx_tcnt_d = '0;
                if (rx_state_q == RX_DATA) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT;
                    rx_valid_d = rx_s2_q;
                    rx_data_d = rx_s2_q ? rx_shift_q : rx_data_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
            tx_state_q <= TX_IDLE;
            tx_tcnt_q <= '0;
            tx_bit_q <= '0;
            tx_shift_q <= '0;
            tx_q <= 1'b1;
            tx_busy_q <= 1'b0;
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q <= '0;
            rx_bit_q <= '0;
            rx_shift_q <= '0;
            rx_data_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_tcnt_q <= tx_tcnt_d;
            tx_bit_q <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q <= tx_d;
            tx_busy_q <= tx_busy_d;
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q <= rx_tcnt_d;
            rx_bit_q <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx = tx_q;
    assign tx_busy = tx_busy_q;
    assign rx_valid = rx_valid_q;
    assign rx_data = rx_data_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core; received bytes are checked
// against a scoreboard queue filled when frames are launched.
`timescale 1ns/1ps
module tb_uart_core;
    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic [7:0] baudrate_cfg = 8'd0;
    logic [7:0] tx_data = 8'd0;
    logic tx_valid = 1'b0;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic rx, tx, tx_busy, rx_valid;
    logic [7:0] rx_data;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] sb[$];
    int rx_times[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
    } rx_vec_t;

    rx_vec_t rv[4];
    logic [7:0] lb[3];

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_core dut (
        .clk(clk), .rstb(rstb), .baudrate_cfg(baudrate_cfg), .rx(rx), .tx(tx),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_valid(rx_valid), .rx_data(rx_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard side: every rx_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (rstb && rx_valid) begin
            rx_times.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected got %02h expected no rx_valid", rx_data);
            end else begin
                chk("rx_data_sb", {24'd0, rx_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (tx_busy && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_idle_wait", {31'd0, tx_busy}, 32'd0);
        tx_valid = 1'b1;
        tx_data = d;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_sb(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 32'd0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        rx_drv = 1'b0;
        repeat (24) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (24) @(negedge clk);
        end
        rx_drv = stop;
        repeat (24) @(negedge clk);
        rx_drv = 1'b1;
        repeat (48) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        logic exp_tx;
        int d;
        rv[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
        rv[1] = '{8'h81, 1'b0, 1'b0, 8'h3C};
        rv[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3};
        rv[3] = '{8'h00, 1'b1, 1'b1, 8'h00};
        lb[0] = 8'h55;
        lb[1] = 8'h00;
        lb[2] = 8'hFF;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rx_drv = 1'($urandom_range(0, 1));
            tx_valid = 1'($urandom_range(0, 1));
            tx_data = 8'($urandom_range(0, 255));
            #1;
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_busy", {31'd0, tx_busy}, 32'd0);
            chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
            chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        rx_drv = 1'b1;
        rstb = 1'b1;
        repeat (4) @(negedge clk);

        // TX waveform of 0xA5 at cfg=0, looped back into RX.
        loop_en = 1'b1;
        pat = 8'hA5;
        sb.push_back(pat);
        tx_data = pat;
        tx_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            exp_tx = (k == 0) ? 1'b1 : (k <= 24) ? 1'b0 : (k < 217) ? pat[(k - 25) / 24] : 1'b1;
            chk($sformatf("wave_tx_k%0d", k), {31'd0, tx}, {31'd0, exp_tx});
            chk($sformatf("wave_busy_k%0d", k), {31'd0, tx_busy}, (k < 240) ? 32'd1 : 32'd0);
        end
        wait_sb(2000);

        // Back-to-back loopback at cfg=18.
        baudrate_cfg = 8'd18;
        rx_times.delete();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(lb[i]);
            send(lb[i]);
        end
        wait_sb(20000);
        chk("lb_count", rx_times.size(), 32'd3);
        for (int i = 1; i < rx_times.size(); i++) begin
            d = rx_times[i] - rx_times[i - 1];
            chk_rng("lb_spacing", d, 4540, 4580);
        end
        chk("lb_last_data", {24'd0, rx_data}, 32'hFF);

        // tx_valid while busy must be ignored.
        baudrate_cfg = 8'd0;
        repeat (30) @(negedge clk);
        sb.push_back(8'h12);
        send(8'h12);
        repeat (100) @(negedge clk);
        tx_data = 8'h34;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_sb(1000);
        repeat (300) @(negedge clk);
        chk("ignore_busy_idle", {31'd0, tx_busy}, 32'd0);
        chk("ignore_rx_data", {24'd0, rx_data}, 32'h12);

        // False start, then the RX frame table (including a framing error).
        loop_en = 1'b0;
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk("false_start_data", {24'd0, rx_data}, 32'h12);
        for (int i = 0; i < 4; i++) begin
            if (rv[i].exp_valid)
                sb.push_back(rv[i].exp_data);
            drive_frame(rv[i].data, rv[i].stop);
            chk($sformatf("rxtab_data_%0d", i), {24'd0, rx_data}, {24'd0, rv[i].exp_data});
            chk($sformatf("rxtab_sb_%0d", i), sb.size(), 32'd0);
        end

        // Reset in the middle of a TX frame (during its start bit).
        loop_en = 1'b1;
        send(8'h77);
        repeat (20) @(negedge clk);
        chk("abort_pre_tx", {31'd0, tx}, 32'd0);
        #2 rstb = 1'b0;
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, tx_busy}, 32'd0);
        chk("abort_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (400) @(negedge clk);
        chk("post_abort_tx", {31'd0, tx}, 32'd1);
        chk("post_abort_busy", {31'd0, tx_busy}, 32'd0);
        chk("post_abort_sb", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
